// File: rtl/vape_pkg.sv
// Shared definitions for the VAPE output-region readout path and the
// output-protection monitor.
package vape_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int MAX_WORDS_DEF = 256;

  // Entry point of the trusted reset handler (MSP430 byte address).
  localparam logic [15:0] RESET_HANDLER = 16'hE000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CAPT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } or_state_t;

endpackage

// File: rtl/vape_or_range_chk.sv
// Combinational OR region check: word-aligned bounds, word count and validity.
// Kept separate so the output-protection monitor can reuse it.
module vape_or_range_chk
  import vape_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic [ADDR_W-1:0] i_or_min,
  input  logic [ADDR_W-1:0] i_or_max,
  output logic [ADDR_W-1:0] o_cur,
  output logic [ADDR_W-1:0] o_end,
  output logic              o_ok
);

  localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  logic [ADDR_W-1:0] w_words;

  // The word count is only meaningful when min < max, so the subtraction
  // never wraps for a region that is accepted.
  always_comb begin
    o_cur   = {i_or_min[ADDR_W-1:1], 1'b0};
    o_end   = {i_or_max[ADDR_W-1:1], 1'b0};
    w_words = ((o_end - o_cur) >> 1) + ONE;
    o_ok    = (i_or_min < i_or_max) && ({1'b0, w_words} <= MAX_CNT);
  end

endmodule

// File: rtl/vape_or_readout.sv
// Streams the VAPE output region word by word to the report engine while the
// output-protection monitor keeps exec high; aborts and flags err otherwise.
module vape_or_readout
  import vape_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              exec,
  input  logic [ADDR_W-1:0] OR_min,
  input  logic [ADDR_W-1:0] OR_max,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(2);

  or_state_t         r_state;
  or_state_t         w_state_next;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_end;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_err;

  logic [ADDR_W-1:0] w_cur0;
  logic [ADDR_W-1:0] w_end0;
  logic              w_rng_ok;

  vape_or_range_chk #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS)
  ) u_rng (
    .i_or_min (OR_min),
    .i_or_max (OR_max),
    .o_cur    (w_cur0),
    .o_end    (w_end0),
    .o_ok     (w_rng_ok)
  );

  // Loss of exec wins over a same-cycle handshake: that word is void.
  always_comb begin
    w_state_next = r_state;
    rd_en        = 1'b0;
    rd_addr      = '0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = r_data;
    busy         = (r_state != ST_IDLE);
    done         = 1'b0;
    err          = r_err;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (exec && w_rng_ok) ? ST_FETCH : ST_ERR;
        end
      end
      ST_FETCH: begin
        rd_en        = 1'b1;
        rd_addr      = r_cur;
        w_state_next = exec ? ST_CAPT : ST_ERR;
      end
      ST_CAPT: begin
        w_state_next = exec ? ST_SEND : ST_ERR;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_last  = r_last;
        if (!exec) begin
          w_state_next = ST_ERR;
        end else if (out_ready) begin
          w_state_next = r_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      ST_ERR: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_end   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cur <= w_cur0;
            r_end <= w_end0;
          end
        end
        ST_CAPT: begin
          r_data <= rd_data;
          r_last <= (r_cur == r_end);
        end
        ST_SEND: begin
          if (exec && out_ready && !r_last) begin
            r_cur <= r_cur + WORD_STEP;
          end
        end
        default: begin
        end
      endcase
      // err is a sticky level: raised on entry to ERR, dropped by an accepted start.
      if (w_state_next == ST_ERR) begin
        r_err <= 1'b1;
      end else if (r_state == ST_IDLE && start) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vape_or_readout.sv
// Self-checking bench for vape_or_readout: transaction-level reference model
// driven by directed scenarios and randomized traffic.
module tb_vape_or_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        exec;
  logic [15:0] OR_min;
  logic [15:0] OR_max;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  vape_or_readout #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .MAX_WORDS (256)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .exec      (exec),
    .OR_min    (OR_min),
    .OR_max    (OR_max),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Word-addressed data memory; read data is only meaningful one cycle after rd_en.
  logic [15:0] mem [0:32767];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr[15:1]];
    else       rd_data <= 16'($urandom);
  end

  localparam logic [15:0] NOM [4] = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state (transaction level).
  bit          mon_en = 1'b0;
  bit          e_busy = 1'b0;
  bit          e_err  = 1'b0;
  bit          e_done = 1'b0;
  bit          e_term = 1'b0;
  bit          e_zero = 1'b0;
  bit          m_active = 1'b0;
  logic [15:0] m_base;
  int          m_n, n_acc, m_fetched, m_start_cyc;
  bit          m_seen_valid;
  bit          p_stall = 1'b0;
  logic [15:0] p_data;
  logic        p_last;
  int          cyc = 0;
  int          txn_id = 0;
  int          mn, mx, cnt;
  bit          ok;
  logic [15:0] a_exp;

  // Statistics consumed by the directed scenarios.
  int          done_cnt, hs_cnt, rden_cnt, ov_cnt, stall_cnt, last_idx, lat_seen;
  logic [15:0] rx_q[$];
  logic [15:0] ad_q[$];

  task automatic clear_stats();
    done_cnt = 0; hs_cnt = 0; rden_cnt = 0; ov_cnt = 0; stall_cnt = 0;
    last_idx = -1; lat_seen = -1;
    rx_q.delete(); ad_q.delete();
  endtask

  function automatic int rx_at(input int i);
    return (i < rx_q.size()) ? int'(rx_q[i]) : -1;
  endfunction

  function automatic int ad_at(input int i);
    return (i < ad_q.size()) ? int'(ad_q[i]) : -1;
  endfunction

  // Compare process: check this cycle against expectations, then advance the model.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      chk("done", int'(done), int'(e_done));
      chk("err", int'(err), int'(e_err));
      chk("busy", int'(busy), int'(e_busy));
      if (done) done_cnt++;
      if (out_valid) ov_cnt++;
      if (e_zero) begin
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", int'(out_data), 0);
      end
      if (!m_active) begin
        chk("rd_en_inactive", int'(rd_en), 0);
        chk("out_valid_inactive", int'(out_valid), 0);
      end
      if (p_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(p_data));
        chk("stall_last", int'(out_last), int'(p_last));
      end
      p_stall = 1'b0;

      if (m_active && !rst) begin
        if (rd_en) begin
          rden_cnt++;
          ad_q.push_back(rd_addr);
          a_exp = m_base + 16'(2 * n_acc);
          chk("fetch_once", m_fetched, n_acc);
          chk("rd_addr", int'(rd_addr), int'(a_exp));
          chk("rd_en_with_valid", int'(out_valid), 0);
          m_fetched++;
        end
        if (out_valid && !m_seen_valid) begin
          m_seen_valid = 1'b1;
          lat_seen = cyc - m_start_cyc;
          chk("first_latency", lat_seen, 3);
        end
        if (out_valid && exec) begin
          a_exp = m_base + 16'(2 * n_acc);
          if (out_ready) begin
            chk("out_data", int'(out_data), int'(mem[a_exp[15:1]]));
            chk("out_last", int'(out_last), int'(n_acc == m_n - 1));
            rx_q.push_back(out_data);
            if (out_last) last_idx = n_acc;
            hs_cnt++;
            n_acc++;
          end else begin
            p_stall   = 1'b1;
            p_data    = out_data;
            p_last    = out_last;
            stall_cnt++;
          end
        end
      end

      e_zero = 1'b0;
      if (rst) begin
        e_busy = 0; e_err = 0; e_done = 0; e_term = 0; e_zero = 1; m_active = 0;
      end else begin
        e_done = 1'b0;
        if (e_term) begin
          e_term = 1'b0;
          e_busy = 1'b0;
        end else if (!e_busy) begin
          if (start) begin
            mn  = int'(OR_min);
            mx  = int'(OR_max);
            cnt = (((mx & ~1) - (mn & ~1)) / 2) + 1;
            ok  = exec && (mn < mx) && (cnt <= 256);
            txn_id++;
            $display("txn %0d: OR_min=%04h OR_max=%04h exec=%0d words=%0d accepted=%0d",
                     txn_id, OR_min, OR_max, exec, ok ? cnt : 0, ok);
            e_busy = 1'b1;
            e_err  = !ok;
            if (ok) begin
              m_active     = 1'b1;
              m_base       = 16'(mn & ~1);
              m_n          = cnt;
              n_acc        = 0;
              m_fetched    = 0;
              m_start_cyc  = cyc;
              m_seen_valid = 1'b0;
            end else begin
              e_term = 1'b1;
            end
          end
        end else if (m_active) begin
          if (!exec) begin
            m_active = 1'b0; e_err = 1'b1; e_term = 1'b1;
          end else if (n_acc == m_n) begin
            m_active = 1'b0; e_done = 1'b1; e_term = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", int'(busy), 0);
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; bounds are scrambled afterwards to test the snapshot.
  task automatic do_start(input logic [15:0] lo, input logic [15:0] hi);
    OR_min = lo; OR_max = hi; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    OR_min = 16'($urandom);
    OR_max = 16'($urandom);
  endtask

  task automatic check_nominal_words(input string tag);
    chk({tag, "_words"}, hs_cnt, 4);
    for (int i = 0; i < 4; i++) chk({tag, "_data"}, rx_at(i), int'(NOM[i]));
  endtask

  initial begin
    int n;
    int len;
    logic [15:0] base;
    rst = 1'b1; start = 1'b0; exec = 1'b1; OR_min = '0; OR_max = '0; out_ready = 1'b1;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[16'h0100 + i] = NOM[i];
    clear_stats();
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal readout of four words.
    clear_stats();
    do_start(16'h0200, 16'h0207);
    wait_idle(100);
    check_nominal_words("nominal");
    chk("nominal_done_pulses", done_cnt, 1);
    chk("nominal_latency", lat_seen, 3);
    chk("nominal_last_idx", last_idx, 3);
    chk("nominal_err", int'(err), 0);

    // Backpressure: hold out_ready low across word 2.
    clear_stats();
    do_start(16'h0200, 16'h0207);
    n = 0;
    while (n_acc < 1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_reach_word2", int'(n_acc >= 1), 1);
    out_ready = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle(100);
    check_nominal_words("bp");
    chk("bp_stall_cycles", stall_cnt, 5);
    chk("bp_rd_en_count", rden_cnt, 4);

    // Degenerate region is rejected without touching memory.
    clear_stats();
    do_start(16'h0300, 16'h0300);
    chk("inv_err_next", int'(err), 1);
    wait_idle(20);
    chk("inv_rd_en_count", rden_cnt, 0);
    chk("inv_out_valid_count", ov_cnt, 0);
    chk("inv_err_sticky", int'(err), 1);
    clear_stats();
    do_start(16'h0200, 16'h0207);
    chk("inv_err_cleared", int'(err), 0);
    wait_idle(100);
    check_nominal_words("after_inv");

    // exec drops while word 2 is offered with out_ready high.
    clear_stats();
    do_start(16'h0200, 16'h0207);
    n = 0;
    while (!(out_valid && n_acc == 1) && n < 50) begin @(posedge clk); #1; n++; end
    chk("xd_reach_word2", int'(out_valid && n_acc == 1), 1);
    exec = 1'b0;
    @(posedge clk); #1;
    exec = 1'b1;
    chk("xd_valid_dropped", int'(out_valid), 0);
    wait_idle(20);
    chk("xd_handshakes", hs_cnt, 1);
    chk("xd_done_pulses", done_cnt, 0);
    chk("xd_err", int'(err), 1);

    // Odd bounds are rounded down to word addresses.
    clear_stats();
    do_start(16'h0201, 16'h0205);
    wait_idle(100);
    chk("odd_words", hs_cnt, 3);
    chk("odd_addr0", ad_at(0), 16'h0200);
    chk("odd_addr1", ad_at(1), 16'h0202);
    chk("odd_addr2", ad_at(2), 16'h0204);
    chk("odd_last_idx", last_idx, 2);

    // Reset in CAPT of word 3, then a clean restart.
    clear_stats();
    do_start(16'h0200, 16'h0207);
    n = 0;
    while (!(rd_en && n_acc == 2) && n < 50) begin @(posedge clk); #1; n++; end
    chk("rst_reach_word3", int'(rd_en && n_acc == 2), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_done", int'(done), 0);
    clear_stats();
    do_start(16'h0200, 16'h0207);
    wait_idle(100);
    chk("restart_addr0", ad_at(0), 16'h0200);
    check_nominal_words("restart");

    // Size boundary: 256 words accepted, 257 rejected; exec low at start rejected.
    clear_stats();
    do_start(16'h1000, 16'h11FF);
    wait_idle(2000);
    chk("max_words", hs_cnt, 256);
    chk("max_err", int'(err), 0);
    clear_stats();
    do_start(16'h1000, 16'h1200);
    wait_idle(20);
    chk("over_err", int'(err), 1);
    chk("over_rd_en", rden_cnt, 0);
    clear_stats();
    exec = 1'b0;
    do_start(16'h0200, 16'h0207);
    exec = 1'b1;
    wait_idle(20);
    chk("noexec_err", int'(err), 1);
    chk("noexec_rd_en", rden_cnt, 0);

    // Randomized traffic: stalls, exec drops, stray starts and bound changes.
    for (int t = 0; t < 40; t++) begin
      base = 16'($urandom);
      case ($urandom % 10)
        0, 1, 2, 3, 4, 5, 6: len = $urandom_range(0, 24);
        7:                   len = 510 + $urandom_range(0, 3);
        default:             len = $urandom_range(0, 65535);
      endcase
      exec = ($urandom % 8) != 0;
      do_start(base, 16'(int'(base) + len));
      n = 0;
      do begin
        out_ready = ($urandom % 3) != 0;
        exec      = ($urandom % 100) != 0;
        start     = ($urandom % 8) == 0;
        OR_min    = 16'($urandom);
        OR_max    = 16'($urandom);
        @(posedge clk); #1;
        n++;
      end while (busy && n < 3000);
      chk("rand_idle_within_budget", int'(busy), 0);
      start = 1'b0; exec = 1'b1; out_ready = 1'b1;
      wait_idle(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
